// File: rtl/reorder_buffer.sv
// Circular reorder buffer: captures decoded instructions, dispatches them in
// order to the RS, collects ALU writebacks and retires at the head.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int OP_W  = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [OP_W-1:0] in_op,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_imm,
    input  logic [31:0]     in_v1,
    input  logic [31:0]     in_v2,
    input  logic [31:0]     in_q1,
    input  logic [31:0]     in_q2,
    input  logic [4:0]      in_rd,
    input  logic            in_is_sl,
    output logic            in_ready,
    input  logic            is_stall_from_rs,
    output logic            is_empty_to_rs,
    output logic            is_sl_to_rs,
    output logic [OP_W-1:0] op_to_rs,
    output logic [31:0]     v1_to_rs,
    output logic [31:0]     v2_to_rs,
    output logic [31:0]     q1_to_rs,
    output logic [31:0]     q2_to_rs,
    output logic [31:0]     imm_to_rs,
    output logic [31:0]     pc_to_rs,
    input  logic            wb_valid,
    input  logic [31:0]     wb_pc,
    input  logic [31:0]     wb_data,
    input  logic            wb_mispredict,
    input  logic [31:0]     wb_target,
    output logic            is_commit_to_rs,
    output logic [31:0]     commit_pc_to_rs,
    output logic [31:0]     commit_data_to_rs,
    output logic [4:0]      commit_rd,
    output logic            is_exception_to_rs,
    output logic [31:0]     redirect_pc
);

    logic [DEPTH-1:0] r_busy, r_done, r_sl, r_mis;
    logic [OP_W-1:0]  r_op   [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_imm  [DEPTH];
    logic [31:0]      r_v1   [DEPTH];
    logic [31:0]      r_v2   [DEPTH];
    logic [31:0]      r_q1   [DEPTH];
    logic [31:0]      r_q2   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_tgt  [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic [IDX_W:0]   r_head, r_tail, r_disp;

    logic [IDX_W-1:0] w_h, w_t, w_d;
    logic             w_full, w_commit, w_flush, w_accept;
    logic             w_avail, w_hold;
    logic [31:0]      w_cv1, w_cq1, w_cv2, w_cq2;
    logic [31:0]      w_pv1, w_pq1, w_pv2, w_pq2;

    assign w_h      = r_head[IDX_W-1:0];
    assign w_t      = r_tail[IDX_W-1:0];
    assign w_d      = r_disp[IDX_W-1:0];
    assign w_full   = (w_h == w_t) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign w_commit = r_busy[w_h] && r_done[w_h];
    assign w_flush  = w_commit && r_mis[w_h];
    assign in_ready = !w_full && !w_flush;
    assign w_accept = in_valid && in_ready;
    assign w_avail  = (r_disp != r_tail);
    // An RS stall only applies to an entry the RS was actually offered.
    assign w_hold   = !is_empty_to_rs && !is_sl_to_rs && is_stall_from_rs;

    assign is_commit_to_rs    = w_commit;
    assign commit_pc_to_rs    = w_commit ? r_pc[w_h] : '0;
    assign commit_data_to_rs  = w_commit ? r_data[w_h] : '0;
    assign commit_rd          = w_commit ? r_rd[w_h] : '0;
    assign is_exception_to_rs = w_flush;
    assign redirect_pc        = w_flush ? r_tgt[w_h] : '0;

    always_comb begin
        w_cv1 = in_v1;
        w_cq1 = in_q1;
        w_cv2 = in_v2;
        w_cq2 = in_q2;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_busy[i] && r_done[i]) begin
                if (in_q1 != '0 && r_pc[i] == in_q1) begin
                    w_cv1 = r_data[i];
                    w_cq1 = '0;
                end
                if (in_q2 != '0 && r_pc[i] == in_q2) begin
                    w_cv2 = r_data[i];
                    w_cq2 = '0;
                end
            end
        end
        if (wb_valid && in_q1 != '0 && wb_pc == in_q1) begin
            w_cv1 = wb_data;
            w_cq1 = '0;
        end
        if (wb_valid && in_q2 != '0 && wb_pc == in_q2) begin
            w_cv2 = wb_data;
            w_cq2 = '0;
        end
    end

    always_comb begin
        w_pv1 = r_v1[w_d];
        w_pq1 = r_q1[w_d];
        w_pv2 = r_v2[w_d];
        w_pq2 = r_q2[w_d];
        if (wb_valid && w_pq1 != '0 && w_pq1 == wb_pc) begin
            w_pv1 = wb_data;
            w_pq1 = '0;
        end
        if (wb_valid && w_pq2 != '0 && w_pq2 == wb_pc) begin
            w_pv2 = wb_data;
            w_pq2 = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_done <= '0;
            r_sl   <= '0;
            r_mis  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= '0;
                r_pc[i]   <= '0;
                r_imm[i]  <= '0;
                r_v1[i]   <= '0;
                r_v2[i]   <= '0;
                r_q1[i]   <= '0;
                r_q2[i]   <= '0;
                r_data[i] <= '0;
                r_tgt[i]  <= '0;
                r_rd[i]   <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_disp         <= '0;
            is_empty_to_rs <= 1'b1;
            is_sl_to_rs    <= 1'b0;
            op_to_rs       <= '0;
            v1_to_rs       <= '0;
            v2_to_rs       <= '0;
            q1_to_rs       <= '0;
            q2_to_rs       <= '0;
            imm_to_rs      <= '0;
            pc_to_rs       <= '0;
        end else if (w_flush) begin
            r_busy         <= '0;
            r_done         <= '0;
            r_mis          <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_disp         <= '0;
            is_empty_to_rs <= 1'b1;
            is_sl_to_rs    <= 1'b0;
            op_to_rs       <= '0;
            v1_to_rs       <= '0;
            v2_to_rs       <= '0;
            q1_to_rs       <= '0;
            q2_to_rs       <= '0;
            imm_to_rs      <= '0;
            pc_to_rs       <= '0;
        end else begin
            if (wb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_busy[i] && r_pc[i] == wb_pc) begin
                        r_done[i] <= 1'b1;
                        r_data[i] <= wb_data;
                        r_mis[i]  <= wb_mispredict;
                        r_tgt[i]  <= wb_target;
                    end
                    if (r_busy[i] && r_q1[i] != '0 && r_q1[i] == wb_pc) begin
                        r_v1[i] <= wb_data;
                        r_q1[i] <= '0;
                    end
                    if (r_busy[i] && r_q2[i] != '0 && r_q2[i] == wb_pc) begin
                        r_v2[i] <= wb_data;
                        r_q2[i] <= '0;
                    end
                end
            end
            if (w_commit) begin
                r_busy[w_h] <= 1'b0;
                r_done[w_h] <= 1'b0;
                r_head      <= r_head + 1'b1;
            end
            if (w_accept) begin
                r_busy[w_t] <= 1'b1;
                r_done[w_t] <= 1'b0;
                r_mis[w_t]  <= 1'b0;
                r_sl[w_t]   <= in_is_sl;
                r_op[w_t]   <= in_op;
                r_pc[w_t]   <= in_pc;
                r_imm[w_t]  <= in_imm;
                r_v1[w_t]   <= w_cv1;
                r_q1[w_t]   <= w_cq1;
                r_v2[w_t]   <= w_cv2;
                r_q2[w_t]   <= w_cq2;
                r_rd[w_t]   <= in_rd;
                r_tail      <= r_tail + 1'b1;
            end
            if (!w_hold) begin
                if (w_avail) begin
                    is_empty_to_rs <= 1'b0;
                    is_sl_to_rs    <= r_sl[w_d];
                    op_to_rs       <= r_op[w_d];
                    v1_to_rs       <= w_pv1;
                    v2_to_rs       <= w_pv2;
                    q1_to_rs       <= w_pq1;
                    q2_to_rs       <= w_pq2;
                    imm_to_rs      <= r_imm[w_d];
                    pc_to_rs       <= r_pc[w_d];
                    r_disp         <= r_disp + 1'b1;
                end else begin
                    is_empty_to_rs <= 1'b1;
                    is_sl_to_rs    <= 1'b0;
                    op_to_rs       <= '0;
                    v1_to_rs       <= '0;
                    v2_to_rs       <= '0;
                    q1_to_rs       <= '0;
                    q2_to_rs       <= '0;
                    imm_to_rs      <= '0;
                    pc_to_rs       <= '0;
                end
            end
        end
    end

endmodule
